mod47_exp_seq: RTL

Sequential modular exponentiator that computes result = base^exponent mod 47 on 6-bit residues. It uses the square-and-multiply method, most significant exponent bit first. It feeds operand pairs into one shared, combinational mult_mod_47_bits multiplier and consumes its output, issuing one modular product per clock. It sits directly upstream and downstream of that multiplier: it sequences the multiplier's inputs and accumulates the multiplier's results.

---
 rtl/mod47_pkg.sv | 10 +
 rtl/mod47_exp_seq_if.sv | 11 +
 rtl/mult_mod_47_bits.sv | 21 ++
 rtl/mod47_exp_seq.sv | 79 +++++++
 4 files changed

// File: rtl/mod47_pkg.sv
// mod47_pkg: shared constants, FSM states and base pre-reduction for the mod-47 exponentiator
package mod47_pkg;
   localparam int RES_W = 6;
   localparam logic [RES_W-1:0] MODULUS = 6'd47;
   typedef enum logic [1:0] {IDLE, SQUARE, MULT, FINISH} state_t;
   // A 6-bit value is below 2*47, so one conditional subtract lands in 0..46
   function automatic logic [RES_W-1:0] reduce47(input logic [RES_W-1:0] x);
      return (x >= MODULUS) ? x - MODULUS : x;
   endfunction
endpackage

// File: rtl/mod47_exp_seq_if.sv
// mod47_exp_seq_if: request/response signals between a client and the mod-47 exponentiator
interface mod47_exp_seq_if #(parameter int EXP_W = 8);
   logic             start;
   logic [5:0]       base;
   logic [EXP_W-1:0] exponent;
   logic             busy;
   logic             done;
   logic [5:0]       result;
   modport master (output start, base, exponent, input busy, done, result);
   modport slave  (input start, base, exponent, output busy, done, result);
endinterface

// File: rtl/mult_mod_47_bits.sv
// mult_mod_47_bits: combinational (a*b) mod 47 for residues a,b in 0..46, bit-serial shift-and-add
module mult_mod_47_bits
   import mod47_pkg::*;
(
   input  logic [RES_W-1:0] a,
   input  logic [RES_W-1:0] b,
   output logic [RES_W-1:0] p
);
   logic [RES_W:0] r;
   // Horner over b's bits keeps every partial sum below 2*47, so each step needs one subtract
   always_comb begin
      r = '0;
      for (int i = RES_W-1; i >= 0; i--) begin
         r = {r[RES_W-1:0], 1'b0};
         r = (r >= {1'b0, MODULUS}) ? r - {1'b0, MODULUS} : r;
         r = b[i] ? r + {1'b0, a} : r;
         r = (r >= {1'b0, MODULUS}) ? r - {1'b0, MODULUS} : r;
      end
   end
   assign p = r[RES_W-1:0];
endmodule

// File: rtl/mod47_exp_seq.sv
// mod47_exp_seq: base^exponent mod 47 by MSB-first square-and-multiply over one shared multiplier
module mod47_exp_seq
   import mod47_pkg::*;
#(
   parameter int EXP_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   mod47_exp_seq_if.slave bus
);
   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   state_t           state, state_n;
   logic [RES_W-1:0] acc, acc_n, b, b_n, result, result_n, op_b, prod;
   logic [EXP_W-1:0] e, e_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic             busy, busy_n, done, done_n;
   assign op_b = (state == MULT) ? b : acc;
   mult_mod_47_bits u_mul (.a(acc), .b(op_b), .p(prod));
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         b      <= '0;
         e      <= '0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_n;
         acc    <= acc_n;
         b      <= b_n;
         e      <= e_n;
         idx    <= idx_n;
         busy   <= busy_n;
         done   <= done_n;
         result <= result_n;
      end
   end
   // busy drops one cycle after FINISH so the done cycle still refuses a new start
   always_comb begin
      state_n  = state;
      acc_n    = acc;
      b_n      = b;
      e_n      = e;
      idx_n    = idx;
      busy_n   = done ? 1'b0 : busy;
      done_n   = 1'b0;
      result_n = result;
      case (state)
         IDLE: if (bus.start && !busy) begin
            b_n     = reduce47(bus.base);
            e_n     = bus.exponent;
            acc_n   = 6'd1;
            idx_n   = IDX_W'(EXP_W-1);
            busy_n  = 1'b1;
            state_n = SQUARE;
         end
         SQUARE: begin
            acc_n   = prod;
            state_n = e[idx] ? MULT : (idx == '0) ? FINISH : SQUARE;
            idx_n   = (!e[idx] && idx != '0) ? idx - 1'b1 : idx;
         end
         MULT: begin
            acc_n   = prod;
            state_n = (idx == '0) ? FINISH : SQUARE;
            idx_n   = (idx == '0) ? idx : idx - 1'b1;
         end
         default: begin
            result_n = acc;
            done_n   = 1'b1;
            state_n  = IDLE;
         end
      endcase
   end
   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.result = result;
endmodule
